// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state encoding, window slot constants and slot index helpers
package sobel_pkg;

    typedef enum logic [3:0] {
        SEQ_IDLE      = 4'd0,
        SEQ_FULL_READ = 4'd1,
        SEQ_SHIFT     = 4'd2,
        SEQ_COL_READ  = 4'd3,
        SEQ_GRAD      = 4'd4,
        SEQ_WAIT_GRAD = 4'd5,
        SEQ_WRITE     = 4'd6,
        SEQ_NEXT      = 4'd7,
        SEQ_DONE      = 4'd8
    } seq_state_t;

    localparam int WIN_SIZE = 3;

    localparam logic [3:0] SLOT_TR   = 4'd2;
    localparam logic [3:0] SLOT_MR   = 4'd5;
    localparam logic [3:0] SLOT_BR   = 4'd8;
    localparam logic [3:0] SLOT_LAST = 4'd8;

    // window row of slot k (k / 3) without a divider
    function automatic logic [1:0] slot_row(input logic [3:0] k);
        if (k >= 4'(2 * WIN_SIZE)) return 2'd2;
        else if (k >= 4'(WIN_SIZE)) return 2'd1;
        else return 2'd0;
    endfunction

    // window column of slot k (k % 3) without a divider
    function automatic logic [1:0] slot_col(input logic [3:0] k);
        logic [3:0] rem;
        rem = k;
        if (rem >= 4'(2 * WIN_SIZE)) rem = rem - 4'(2 * WIN_SIZE);
        else if (rem >= 4'(WIN_SIZE)) rem = rem - 4'(WIN_SIZE);
        return 2'(rem);
    endfunction

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// rtl/sobel_window_sequencer_if.sv - memory, window buffer and gradient handshake bundle
interface sobel_window_sequencer_if #(parameter int ADDR_W = 19);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [3:0]        win_slot;
    logic              win_shift;
    logic              grad_start;
    logic              h_done;
    logic              v_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_zero;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, win_slot, win_shift, grad_start, wr_req, wr_addr, wr_zero,
        input  rd_ack, h_done, v_done, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, win_slot, win_shift, grad_start, wr_req, wr_addr, wr_zero,
        output rd_ack, h_done, v_done, wr_ack
    );
endinterface

// File: rtl/sobel_addr_gen.sv
// rtl/sobel_addr_gen.sv - centre counters and multiplier-free read/write addresses (SOBEL_SEQ_ZERO_BORDER_EN)
module sobel_addr_gen import sobel_pkg::*; #(
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic              wr_inc,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);
    localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_W);
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
    // centre walks the whole image; the window top row starts one row above row 0
    localparam logic [ADDR_W-1:0] C_FIRST    = '0;
    localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] R_FIRST    = '0;
    localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'(0) - W;
`else
    localparam logic [ADDR_W-1:0] C_FIRST    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] R_FIRST    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BASE_FIRST = '0;
`endif

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] wr_cnt;

    // raster walk of the centre; row_base tracks (row-1)*IMG_W by repeated addition
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            wr_cnt   <= '0;
        end else if (load) begin
            row      <= R_FIRST;
            col      <= C_FIRST;
            row_base <= BASE_FIRST;
            wr_cnt   <= '0;
        end else begin
            if (adv) begin
                if (col == C_LAST) begin
                    col      <= C_FIRST;
                    row      <= row + ADDR_W'(1);
                    row_base <= row_base + W;
                end else begin
                    col <= col + ADDR_W'(1);
                end
            end
            if (wr_inc) wr_cnt <= wr_cnt + ADDR_W'(1);
        end
    end

    // window row offset for slot k: 0, IMG_W or 2*IMG_W
    always_comb begin
        row_off = '0;
        case (slot_row(k))
            2'd1:    row_off = W;
            2'd2:    row_off = W + W;
            default: row_off = '0;
        endcase
    end

    assign rd_addr = row_base + row_off + col + ADDR_W'(slot_col(k)) - ADDR_W'(1);
    assign wr_addr = wr_cnt;
endmodule

// File: rtl/sobel_window_sequencer.sv
// rtl/sobel_window_sequencer.sv - 3x3 Sobel window walk controller (SOBEL_SEQ_ZERO_BORDER_EN)
module sobel_window_sequencer import sobel_pkg::*; #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      all_done,
    sobel_window_sequencer_if.master  bus
);
    localparam logic [3:0] IDLE      = 4'(SEQ_IDLE);
    localparam logic [3:0] FULL_READ = 4'(SEQ_FULL_READ);
    localparam logic [3:0] SHIFT     = 4'(SEQ_SHIFT);
    localparam logic [3:0] COL_READ  = 4'(SEQ_COL_READ);
    localparam logic [3:0] GRAD      = 4'(SEQ_GRAD);
    localparam logic [3:0] WAIT_GRAD = 4'(SEQ_WAIT_GRAD);
    localparam logic [3:0] WRITE     = 4'(SEQ_WRITE);
    localparam logic [3:0] NEXT      = 4'(SEQ_NEXT);
    localparam logic [3:0] DONE      = 4'(SEQ_DONE);

    localparam logic [ADDR_W-1:0] COL_END = ADDR_W'(IMG_W - 2);

    logic [3:0]        state;
    logic [3:0]        k;
    logic              h_seen, v_seen, grads_done;
    logic              rd_req_i, wr_req_i;
    logic [ADDR_W-1:0] row, col, rd_addr_raw, wr_addr_raw;

    sobel_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (state == IDLE && start),
        .adv     (state == NEXT),
        .wr_inc  (state == WRITE && bus.wr_ack),
        .k       (k),
        .row     (row),
        .col     (col),
        .rd_addr (rd_addr_raw),
        .wr_addr (wr_addr_raw)
    );

    // a completion pulse in the current cycle counts as if already latched
    assign grads_done = (h_seen | bus.h_done) & (v_seen | bus.v_done);

`ifdef SOBEL_SEQ_ZERO_BORDER_EN
    localparam logic [ADDR_W-1:0] EDGE_C = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] EDGE_R = ADDR_W'(IMG_H - 1);
    logic on_border, next_border, frame_end, row_entry;
    assign on_border   = (row == '0) || (row == EDGE_R) || (col == '0) || (col == EDGE_C);
    assign frame_end   = (col == EDGE_C) && (row == EDGE_R);
    // the pixel after (row,col) is a border pixel when it wraps, lands on the last column or stays on an edge row
    assign next_border = (col == EDGE_C) || (col == COL_END) || (row == '0) || (row == EDGE_R);
    assign row_entry   = (col == '0);
    assign bus.wr_zero = wr_req_i && on_border;
`else
    localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(IMG_H - 2);
    assign bus.wr_zero = 1'b0;
`endif

    assign rd_req_i       = (state == FULL_READ) || (state == COL_READ);
    assign wr_req_i       = (state == WRITE);
    assign bus.rd_req     = rd_req_i;
    assign bus.rd_addr    = rd_req_i ? rd_addr_raw : '0;
    assign bus.win_slot   = rd_req_i ? k : 4'd0;
    assign bus.win_shift  = (state == SHIFT);
    assign bus.grad_start = (state == GRAD);
    assign bus.wr_req     = wr_req_i;
    assign bus.wr_addr    = wr_req_i ? wr_addr_raw : '0;
    assign busy           = (state != IDLE);
    assign all_done       = (state == DONE);

    // window walk: fetch phases, gradient handshake, result write, advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 4'd0;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k <= 4'd0;
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
                    state <= WRITE;
`else
                    state <= FULL_READ;
`endif
                end
                FULL_READ: if (bus.rd_ack) begin
                    if (k == SLOT_LAST) state <= GRAD;
                    else k <= k + 4'd1;
                end
                SHIFT: begin
                    k     <= SLOT_TR;
                    state <= COL_READ;
                end
                COL_READ: if (bus.rd_ack) begin
                    if (k == SLOT_BR) state <= GRAD;
                    else k <= (k == SLOT_TR) ? SLOT_MR : SLOT_BR;
                end
                GRAD: begin
                    h_seen <= 1'b0;
                    v_seen <= 1'b0;
                    state  <= WAIT_GRAD;
                end
                WAIT_GRAD: begin
                    if (bus.h_done) h_seen <= 1'b1;
                    if (bus.v_done) v_seen <= 1'b1;
                    if (grads_done) state <= WRITE;
                end
                WRITE: if (bus.wr_ack) state <= NEXT;
                NEXT: begin
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
                    if (frame_end) state <= DONE;
                    else if (next_border) state <= WRITE;
                    else if (row_entry) begin
                        k     <= 4'd0;
                        state <= FULL_READ;
                    end else state <= SHIFT;
`else
                    if (col != COL_END) state <= SHIFT;
                    else if (row != ROW_END) begin
                        k     <= 4'd0;
                        state <= FULL_READ;
                    end else state <= DONE;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_sequencer.sv
// tb/tb_sobel_window_sequencer.sv - randomized bench against a frame-level window walk model (SOBEL_SEQ_ZERO_BORDER_EN)
module tb_sobel_window_sequencer;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, all_done;

    sobel_window_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    sobel_window_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .all_done (all_done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // expected and observed transactions: reads as slot*4096+addr, writes as addr*2+zero
    int exp_rd[$], act_rd[$], exp_wr[$], act_wr[$];
    int exp_shift, exp_grad, exp_first_rd_wr;
    int shift_cnt, grad_cnt, done_cnt, first_rd_wr;

    // responder knobs and state
    int rd_max = 0, wr_max = 0, gd_mode = 0;
    bit rd_fix = 0;
    int cyc = 0;
    int rd_wait, rd_dly, wr_wait, wr_dly, h_cnt, v_cnt, both_cyc, last_ack_cyc;
    bit rd_hold, prev_wr, grad_pend, h_got, v_got, in_col, col_rd_seen;
    logic [ADDR_W-1:0] prev_addr;
    logic [3:0] prev_slot;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, longint'({busy, all_done, bus.rd_req, bus.rd_addr, bus.win_slot, bus.win_shift,
                                bus.grad_start, bus.wr_req, bus.wr_addr, bus.wr_zero}), 0);
    endtask

    // whole-frame expectation from the raster walk rules
    task automatic build_model();
        int r0, r1, c0, c1, waddr;
        bit brd;
        exp_rd.delete();
        exp_wr.delete();
        exp_shift = 0;
        exp_grad = 0;
        exp_first_rd_wr = -1;
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
        r0 = 0; r1 = IMG_H - 1; c0 = 0; c1 = IMG_W - 1;
`else
        r0 = 1; r1 = IMG_H - 2; c0 = 1; c1 = IMG_W - 2;
`endif
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                brd = (r == 0) || (r == IMG_H - 1) || (c == 0) || (c == IMG_W - 1);
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
                waddr = r * IMG_W + c;
`else
                waddr = (r - 1) * (IMG_W - 2) + (c - 1);
`endif
                if (!brd) begin
                    if (exp_first_rd_wr < 0) exp_first_rd_wr = exp_wr.size();
                    exp_grad++;
                    if (c == 1) begin
                        for (int k = 0; k < 9; k++)
                            exp_rd.push_back(k * 4096 + (r - 1 + k / 3) * IMG_W + (c - 1 + k % 3));
                    end else begin
                        exp_shift++;
                        for (int i = 0; i < 3; i++)
                            exp_rd.push_back((3 * i + 2) * 4096 + (r - 1 + i) * IMG_W + c + 1);
                    end
                end
                exp_wr.push_back(waddr * 2 + int'(brd));
            end
        end
    endtask

    // memory / gradient responder and protocol monitor, all on the falling edge
    initial begin
        bus.rd_ack = 1'b0;
        bus.wr_ack = 1'b0;
        bus.h_done = 1'b0;
        bus.v_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.rd_ack = 1'b0;
            bus.wr_ack = 1'b0;
            bus.h_done = 1'b0;
            bus.v_done = 1'b0;
            if (rst) begin
                rd_wait = 0; wr_wait = 0; h_cnt = 0; v_cnt = 0;
                rd_hold = 0; prev_wr = 0; grad_pend = 0; in_col = 0;
            end else begin
                if (h_cnt > 0) begin
                    h_cnt--;
                    if (h_cnt == 0) begin bus.h_done = 1'b1; h_got = 1; end
                end
                if (v_cnt > 0) begin
                    v_cnt--;
                    if (v_cnt == 0) begin bus.v_done = 1'b1; v_got = 1; end
                end
                if (grad_pend && h_got && v_got && both_cyc < 0) both_cyc = cyc;
                if (bus.rd_req && $urandom_range(7, 0) == 0) bus.h_done = 1'b1;

                if (bus.rd_req) begin
                    if (in_col) col_rd_seen = 1;
                    if (rd_hold) begin
                        check_eq("rd_addr_hold", bus.rd_addr, prev_addr);
                        check_eq("win_slot_hold", bus.win_slot, prev_slot);
                    end
                    if (rd_wait == 0) rd_dly = rd_fix ? rd_max : int'($urandom_range(rd_max, 0));
                    if (rd_wait == rd_dly) begin
                        bus.rd_ack = 1'b1;
                        if (act_rd.size() == 0) first_rd_wr = act_wr.size();
                        act_rd.push_back(int'(bus.win_slot) * 4096 + int'(bus.rd_addr));
                        rd_wait = 0;
                        rd_hold = 0;
                        last_ack_cyc = cyc;
                    end else begin
                        rd_wait++;
                        rd_hold = 1;
                        prev_addr = bus.rd_addr;
                        prev_slot = bus.win_slot;
                    end
                end else if (rd_hold) begin
                    check_eq("rd_req_hold", bus.rd_req, 1);
                    rd_hold = 0;
                end

                if (bus.wr_req) begin
                    if (!prev_wr && grad_pend) begin
                        check_eq("wr_after_grads", (both_cyc < 0) ? -1 : (cyc - both_cyc), 1);
                        grad_pend = 0;
                    end
                    if (wr_wait == 0) wr_dly = int'($urandom_range(wr_max, 0));
                    if (wr_wait == wr_dly) begin
                        bus.wr_ack = 1'b1;
                        act_wr.push_back(int'(bus.wr_addr) * 2 + int'(bus.wr_zero));
                        wr_wait = 0;
                    end else wr_wait++;
                end
                prev_wr = bus.wr_req;

                if (bus.grad_start) begin
                    grad_cnt++;
                    check_eq("grad_after_last_ack", cyc - last_ack_cyc, 1);
                    grad_pend = 1; h_got = 0; v_got = 0; both_cyc = -1; in_col = 0;
                    case (gd_mode)
                        1: begin h_cnt = 1; v_cnt = 5; end
                        2: begin h_cnt = int'($urandom_range(4, 1)); v_cnt = h_cnt; end
                        default: begin h_cnt = int'($urandom_range(6, 1)); v_cnt = int'($urandom_range(6, 1)); end
                    endcase
                end
                if (bus.win_shift) begin shift_cnt++; in_col = 1; end
                if (all_done) done_cnt++;
            end
        end
    end

    task automatic run_frame(input int rmax, input bit rfix, input int wmax, input int gmode, input bit poke);
        int n;
        rd_max = rmax; rd_fix = rfix; wr_max = wmax; gd_mode = gmode;
        build_model();
        act_rd.delete();
        act_wr.delete();
        shift_cnt = 0; grad_cnt = 0; done_cnt = 0; first_rd_wr = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
`ifdef SOBEL_SEQ_ZERO_BORDER_EN
        check_eq("first_wr_req", bus.wr_req, 1);
        check_eq("first_wr_zero", bus.wr_zero, 1);
`else
        check_eq("first_rd_req", bus.rd_req, 1);
        check_eq("first_rd_addr", bus.rd_addr, 0);
`endif
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(posedge clk);
            n++;
            if (poke && n == 20) begin #1 start = 1'b1; end
            if (poke && n == 21) begin #1 start = 1'b0; end
        end
        start = 1'b0;
        #1;
        check_eq("busy_after_done", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("all_done_count", done_cnt, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("rd_count", act_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++) begin
            check_eq($sformatf("rd_addr[%0d]", i), act_rd[i] % 4096, exp_rd[i] % 4096);
            check_eq($sformatf("rd_slot[%0d]", i), act_rd[i] / 4096, exp_rd[i] / 4096);
        end
        check_eq("wr_count", act_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), act_wr[i] / 2, exp_wr[i] / 2);
            check_eq($sformatf("wr_zero[%0d]", i), act_wr[i] % 2, exp_wr[i] % 2);
        end
        check_eq("shift_count", shift_cnt, exp_shift);
        check_eq("grad_count", grad_cnt, exp_grad);
        check_eq("writes_before_first_read", first_rd_wr, exp_first_rd_wr);
    endtask

    task automatic reset_mid_frame();
        int n;
        rd_max = 5; rd_fix = 1; wr_max = 0; gd_mode = 0;
        col_rd_seen = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!col_rd_seen && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("col_read_reached", col_rd_seen, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("outputs_after_mid_reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_done_after_reset", done_cnt, 0);
        check_eq("idle_after_reset", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        run_frame(0, 1, 0, 0, 0);
        run_frame(3, 0, 2, 0, 0);
        run_frame(2, 0, 1, 1, 0);
        run_frame(1, 0, 0, 2, 0);
        run_frame(5, 1, 2, 0, 1);
        reset_mid_frame();
        run_frame(2, 0, 2, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sobel_window_sequencer.md
# sobel_window_sequencer

Controller that walks a 3x3 Sobel window across a stored grayscale image. It fetches window pixels from pixel memory into the window buffer, using a full 9-pixel load at the start of each row and a shift plus 3 new pixels on every later column. For each window it starts the horizontal and vertical gradient units, waits for both to finish, then commits the result to the output memory. It sits between the top-level start/done interface and the memory, window-buffer and gradient datapath.

## Interface
- IMG_W, 640, image width in pixels (>= 3)
- IMG_H, 480, image height in pixels (>= 3)
- ADDR_W, $clog2(IMG_W*IMG_H), memory address width
- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- start  in  1  start-frame pulse; sampled only in IDLE
- rd_req  out  1  pixel read request; held until rd_ack
- rd_addr  out  ADDR_W  pixel address row*IMG_W+col; stable while rd_req=1
- rd_ack  in  1  read data valid; the window buffer captures into win_slot on this edge
- win_slot  out  4  destination slot 0..8 (3*dr+dc); stable while rd_req=1
- win_shift  out  1  one-cycle pulse: window buffer shifts left one column
- grad_start  out  1  one-cycle pulse: start both gradient units
- h_done, v_done  in  1  one-cycle completion pulses; any order, may coincide
- wr_req  out  1  result write request; held until wr_ack
- wr_addr  out  ADDR_W  output address
- wr_zero  out  1  write a zero instead of the gradient result (border only)
- wr_ack  in  1  write accepted
- busy  out  1  high from the cycle after start is accepted through DONE
- all_done  out  1  one-cycle end-of-frame pulse

## Operation
- State machine states: IDLE, FULL_READ, SHIFT, COL_READ, GRAD, WAIT_GRAD, WRITE, NEXT, DONE.
- Window centre (r,c): r in 1..IMG_H-2, c in 1..IMG_W-2, visited in raster order.
- IDLE -> FULL_READ when start=1. The counters load r=1, c=1 and the read index k=0.
- FULL_READ issues 9 reads in row-major order. Read k addresses (r-1+k/3, c-1+k%3) into slot k. After the 9th rd_ack, go to GRAD.
- SHIFT pulses win_shift for one cycle, then goes to COL_READ.
- COL_READ issues 3 reads at (r-1+i, c+1) into slots 2, 5, 8 for i=0..2, then goes to GRAD.
- GRAD pulses grad_start and clears the h/v sticky flags, then goes to WAIT_GRAD.
- WAIT_GRAD sets a sticky flag on each h_done or v_done pulse. It exits to WRITE in the cycle both flags are set, including a same-cycle pulse of both.
- WRITE holds wr_req until wr_ack. wr_addr = (r-1)*(IMG_W-2)+(c-1).
- NEXT:
  - if c < IMG_W-2: c++ and go to SHIFT.
  - else if r < IMG_H-2: r++, c=1, go to FULL_READ.
  - else go to DONE.
- DONE asserts all_done for one cycle, then returns to IDLE.
- Address arithmetic uses no multiplier. Row-base registers advance by IMG_W per row; output addresses come from a counter incremented once per write. All arithmetic is unsigned ADDR_W.
- h_done or v_done pulses outside WAIT_GRAD are ignored. start while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- rst asserted mid-frame: IDLE on the next edge. Any outstanding rd_req/wr_req drops with no completion, and all_done is not pulsed.
- Latency from start to first rd_req: 1 cycle. The start cycle is in IDLE, and rd_req is high in the next cycle.
- Each read takes at least 1 cycle, because rd_ack may arrive in the same cycle as rd_req. The next request's address appears in the cycle after the ack.
- grad_start occurs exactly 1 cycle after the last rd_ack.
- wr_req rises the cycle after the exit condition of WAIT_GRAD is met.
- Minimum cycles per non-first-column window with zero-wait acks: SHIFT 1 + reads 3 + GRAD 1 + WAIT_GRAD >= 1 + WRITE 1 + NEXT 1.

## Configuration
- Macro: SOBEL_SEQ_ZERO_BORDER_EN.
- Without the macro:
  - the output image is (IMG_W-2)x(IMG_H-2), packed;
  - wr_zero is tied to 0.
- With the macro:
  - the output is IMG_W x IMG_H, with wr_addr = r*IMG_W+c, and r, c span the full image in raster order;
  - each border pixel (r or c at an edge) goes directly from NEXT to WRITE with wr_zero=1, with no reads and no grad_start;
  - the first interior pixel of each row uses FULL_READ, and later interior pixels use SHIFT.

## Structure
- Shared package sobel_pkg: seq_state_t enum, window slot constants (SLOT_TR=2, SLOT_MR=5, SLOT_BR=8), and the window size constant 3.
- One sub-module, sobel_addr_gen:
  - holds the r/c counters and row-base registers;
  - produces rd_addr and wr_addr from the k/i index.
- The FSM stays in sobel_window_sequencer.

## Test plan
- IMG_W=5, IMG_H=4, zero-wait acks, start pulse:
  - first 9 rd_addr are 0,1,2,5,6,7,10,11,12 with win_slot 0..8;
  - then grad_start;
  - after h_done, wr_addr=0.
- Same run, second window:
  - win_shift pulse, then rd_addr 3,8,13 on slots 2,5,8;
  - frame totals: 30 reads and 6 writes with wr_addr 0..5;
  - all_done pulses once, then busy=0.
- In WAIT_GRAD: h_done alone -> no wr_req; v_done 4 cycles later -> wr_req the next cycle. h_done and v_done in the same cycle -> wr_req the next cycle.
- rd_ack delayed 5 cycles: rd_addr and win_slot stay stable and rd_req stays high. start pulsed mid-frame has no effect.
- rst asserted during COL_READ: the next cycle has all outputs 0. A new start restarts at rd_addr 0.
- With SOBEL_SEQ_ZERO_BORDER_EN, 5x4 image:
  - 20 writes with wr_addr 0..19;
  - wr_zero=1 on the 14 border addresses;
  - the first read happens after the write to wr_addr 5.
